minmax_window: RTL and testbench

Windowed min/max/threshold statistics stage that sits directly downstream of the datapath comparator stage. It consumes a stream of DATAWIDTH-bit unsigned samples over a valid/ready handshake and accumulates WINDOW samples per window. At the end of each window it reports the minimum, the maximum, and the count of samples strictly above a threshold. The report is held on a valid/ready output until it is consumed. Magnitude decisions use the same unsigned gt/lt/eq semantics as the comparator, so COMP instances may be used internally.

---
 rtl/minmax_window_if.sv | 39 +++
 rtl/minmax_window.sv | 115 +++++++++++
 tb/tb_minmax_window.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/minmax_window_if.sv
// Stream interface for minmax_window: sample input, report output and clear.
// The index ports exist only when MINMAX_INDEX_EN is defined.
interface minmax_window_if #(
   parameter int DATAWIDTH = 16,
   parameter int CNTW      = 4
);
   logic                 clear;
   logic                 in_valid;
   logic                 in_ready;
   logic [DATAWIDTH-1:0] in_data;
   logic [DATAWIDTH-1:0] thr;
   logic                 out_valid;
   logic                 out_ready;
   logic [DATAWIDTH-1:0] out_min;
   logic [DATAWIDTH-1:0] out_max;
   logic [CNTW-1:0]      out_above;
`ifdef MINMAX_INDEX_EN
   logic [CNTW-1:0]      out_min_idx;
   logic [CNTW-1:0]      out_max_idx;
`endif

   // Producer/consumer side.
   modport master (
      output clear, in_valid, in_data, thr, out_ready,
      input  in_ready, out_valid, out_min, out_max, out_above
`ifdef MINMAX_INDEX_EN
      , input out_min_idx, out_max_idx
`endif
   );

   // Statistics block side.
   modport slave (
      input  clear, in_valid, in_data, thr, out_ready,
      output in_ready, out_valid, out_min, out_max, out_above
`ifdef MINMAX_INDEX_EN
      , output out_min_idx, out_max_idx
`endif
   );
endinterface

// File: rtl/minmax_window.sv
// Windowed min/max/above-threshold statistics over WINDOW unsigned samples.
// Optional MINMAX_INDEX_EN adds the in-window position of the min and max.
module minmax_window #(
   parameter int DATAWIDTH = 16,
   parameter int WINDOW    = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   minmax_window_if.slave bus
);
   localparam int CNTW = $clog2(WINDOW + 1);
   localparam logic [CNTW-1:0] LAST = CNTW'(WINDOW - 1);

   typedef enum logic {ACCUM, REPORT} state_t;

   state_t               state_q, state_d;
   logic [CNTW-1:0]      cnt_q;
   logic [DATAWIDTH-1:0] min_q, max_q, out_min_q, out_max_q;
   logic [CNTW-1:0]      above_q, out_above_q;

   logic                 accept, first, last, lt_min, gt_max, gt_thr;
   logic [DATAWIDTH-1:0] min_nx, max_nx;
   logic [CNTW-1:0]      above_nx;

`ifdef MINMAX_INDEX_EN
   logic [CNTW-1:0]      min_idx_q, max_idx_q, out_min_idx_q, out_max_idx_q;
   logic [CNTW-1:0]      min_idx_nx, max_idx_nx;
`endif

   // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      accept   = bus.in_valid && (state_q == ACCUM);
      first    = (cnt_q == '0);
      last     = (cnt_q == LAST);
      lt_min   = bus.in_data < min_q;
      gt_max   = bus.in_data > max_q;
      gt_thr   = bus.in_data > bus.thr;
      // Strict compares: a tie keeps the earlier sample.
      min_nx   = (first || lt_min) ? bus.in_data : min_q;
      max_nx   = (first || gt_max) ? bus.in_data : max_q;
      above_nx = (first ? '0 : above_q) + CNTW'(gt_thr);
`ifdef MINMAX_INDEX_EN
      min_idx_nx = first ? '0 : (lt_min ? cnt_q : min_idx_q);
      max_idx_nx = first ? '0 : (gt_max ? cnt_q : max_idx_q);
`endif
   end

   always_comb begin
      state_d = state_q;
      if (bus.clear) begin
         state_d = ACCUM;
      end else begin
         case (state_q)
            ACCUM:   if (accept && last) state_d = REPORT;
            REPORT:  if (bus.out_ready)  state_d = ACCUM;
            default: state_d = ACCUM;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ACCUM;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         min_q       <= '0;
         max_q       <= '0;
         above_q     <= '0;
         out_min_q   <= '0;
         out_max_q   <= '0;
         out_above_q <= '0;
`ifdef MINMAX_INDEX_EN
         min_idx_q     <= '0;
         max_idx_q     <= '0;
         out_min_idx_q <= '0;
         out_max_idx_q <= '0;
`endif
      end else if (bus.clear) begin
         // Accumulators need no wipe: the next first sample overwrites them.
         cnt_q <= '0;
      end else if (accept) begin
         cnt_q   <= last ? '0 : cnt_q + CNTW'(1);
         min_q   <= min_nx;
         max_q   <= max_nx;
         above_q <= above_nx;
`ifdef MINMAX_INDEX_EN
         min_idx_q <= min_idx_nx;
         max_idx_q <= max_idx_nx;
`endif
         if (last) begin
            out_min_q   <= min_nx;
            out_max_q   <= max_nx;
            out_above_q <= above_nx;
`ifdef MINMAX_INDEX_EN
            out_min_idx_q <= min_idx_nx;
            out_max_idx_q <= max_idx_nx;
`endif
         end
      end
   end

   assign bus.in_ready  = (state_q == ACCUM);
   assign bus.out_valid = (state_q == REPORT);
   assign bus.out_min   = out_min_q;
   assign bus.out_max   = out_max_q;
   assign bus.out_above = out_above_q;
`ifdef MINMAX_INDEX_EN
   assign bus.out_min_idx = out_min_idx_q;
   assign bus.out_max_idx = out_max_idx_q;
`endif
endmodule

// File: tb/tb_minmax_window.sv
// Directed self-checking bench for minmax_window (WINDOW=8, 16-bit samples).
// Index checks are compiled in when MINMAX_INDEX_EN is defined.
module tb_minmax_window;
   localparam int DW   = 16;
   localparam int WIN  = 8;
   localparam int CNTW = 4;

   logic clk = 1'b0;
   logic rst_n;
   int   vectors = 0;
   int   miscompares = 0;

   minmax_window_if #(.DATAWIDTH(DW), .CNTW(CNTW)) bus ();

   minmax_window #(.DATAWIDTH(DW), .WINDOW(WIN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   // Present one sample at a negedge and return at the negedge after it is accepted.
   task automatic push(input logic [DW-1:0] d, input logic [DW-1:0] t);
      int waited = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.thr      = t;
      while (!bus.in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 50) begin
         miscompares++;
         $display("FAIL push_timeout: in_ready=%0b after %0d cycles, required 1", bus.in_ready, waited);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      vectors++;
      if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
         miscompares++;
         $display("FAIL reset_handshake: got in_ready/out_valid=%b required 10", {bus.in_ready, bus.out_valid});
      end
      vectors++;
      if ({bus.out_min, bus.out_max, bus.out_above} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got min=%0d max=%0d above=%0d required 0/0/0", bus.out_min, bus.out_max, bus.out_above);
      end
`ifdef MINMAX_INDEX_EN
      vectors++;
      if ({bus.out_min_idx, bus.out_max_idx} !== '0) begin
         miscompares++;
         $display("FAIL reset_idx: got %0d/%0d required 0/0", bus.out_min_idx, bus.out_max_idx);
      end
`endif
   endtask

   task automatic test_basic();
      logic [DW-1:0] s [8] = '{16'd5, 16'd3, 16'd9, 16'd3, 16'd12, 16'd0, 16'd7, 16'd12};
      bus.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) push(s[i], 16'd6);
      vectors++;
      if ({bus.out_valid, bus.out_min, bus.out_max, bus.out_above} !== {1'b1, 16'd0, 16'd12, 4'd4}) begin
         miscompares++;
         $display("FAIL basic_report: got v=%0b min=%0d max=%0d above=%0d required 1/0/12/4",
                  bus.out_valid, bus.out_min, bus.out_max, bus.out_above);
      end
`ifdef MINMAX_INDEX_EN
      vectors++;
      if ({bus.out_min_idx, bus.out_max_idx} !== {4'd5, 4'd4}) begin
         miscompares++;
         $display("FAIL basic_idx: got %0d/%0d required 5/4", bus.out_min_idx, bus.out_max_idx);
      end
`endif
      @(negedge clk);
      vectors++;
      if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
         miscompares++;
         $display("FAIL basic_consumed: got in_ready/out_valid=%b required 10", {bus.in_ready, bus.out_valid});
      end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] s [8] = '{16'd50, 16'd40, 16'd60, 16'd45, 16'd55, 16'd41, 16'd59, 16'd42};
      bus.out_ready = 1'b0;
      for (int i = 0; i < 8; i++) push(16'd100 + 16'(i), 16'd103);
      // Hold the next window's first sample while the report is stalled.
      bus.in_valid = 1'b1;
      bus.in_data  = s[0];
      bus.thr      = 16'd50;
      for (int c = 0; c < 5; c++) begin
         vectors++;
         if ({bus.out_valid, bus.in_ready, bus.out_min, bus.out_max, bus.out_above} !==
             {1'b1, 1'b0, 16'd100, 16'd107, 4'd4}) begin
            miscompares++;
            $display("FAIL bp_hold_c%0d: got v=%0b rdy=%0b min=%0d max=%0d above=%0d required 1/0/100/107/4",
                     c, bus.out_valid, bus.in_ready, bus.out_min, bus.out_max, bus.out_above);
         end
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
         miscompares++;
         $display("FAIL bp_release: got in_ready/out_valid=%b required 10", {bus.in_ready, bus.out_valid});
      end
      for (int i = 0; i < 8; i++) push(s[i], 16'd50);
      vectors++;
      if ({bus.out_valid, bus.out_min, bus.out_max, bus.out_above} !== {1'b1, 16'd40, 16'd60, 4'd3}) begin
         miscompares++;
         $display("FAIL bp_next_report: got v=%0b min=%0d max=%0d above=%0d required 1/40/60/3",
                  bus.out_valid, bus.out_min, bus.out_max, bus.out_above);
      end
`ifdef MINMAX_INDEX_EN
      vectors++;
      if ({bus.out_min_idx, bus.out_max_idx} !== {4'd1, 4'd2}) begin
         miscompares++;
         $display("FAIL bp_idx: got %0d/%0d required 1/2", bus.out_min_idx, bus.out_max_idx);
      end
`endif
      @(negedge clk);
   endtask

   task automatic test_all_equal();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) push(16'hFFFF, 16'hFFFF);
      vectors++;
      if ({bus.out_valid, bus.out_min, bus.out_max, bus.out_above} !== {1'b1, 16'hFFFF, 16'hFFFF, 4'd0}) begin
         miscompares++;
         $display("FAIL equal_report: got v=%0b min=%h max=%h above=%0d required 1/ffff/ffff/0",
                  bus.out_valid, bus.out_min, bus.out_max, bus.out_above);
      end
`ifdef MINMAX_INDEX_EN
      vectors++;
      if ({bus.out_min_idx, bus.out_max_idx} !== '0) begin
         miscompares++;
         $display("FAIL equal_idx: got %0d/%0d required 0/0", bus.out_min_idx, bus.out_max_idx);
      end
`endif
      @(negedge clk);
   endtask

   task automatic test_clear();
      logic [DW-1:0] pre [4] = '{16'd100, 16'd200, 16'd0, 16'd300};
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) push(pre[i], 16'd0);
      // Clear beats a same-cycle accept: the 0 sample must not land.
      bus.clear    = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 16'd0;
      @(negedge clk);
      bus.clear    = 1'b0;
      bus.in_valid = 1'b0;
      for (int i = 1; i <= 8; i++) push(16'(i), 16'd0);
      vectors++;
      if ({bus.out_valid, bus.out_min, bus.out_max, bus.out_above} !== {1'b1, 16'd1, 16'd8, 4'd8}) begin
         miscompares++;
         $display("FAIL clear_report: got v=%0b min=%0d max=%0d above=%0d required 1/1/8/8",
                  bus.out_valid, bus.out_min, bus.out_max, bus.out_above);
      end
`ifdef MINMAX_INDEX_EN
      vectors++;
      if ({bus.out_min_idx, bus.out_max_idx} !== {4'd0, 4'd7}) begin
         miscompares++;
         $display("FAIL clear_idx: got %0d/%0d required 0/7", bus.out_min_idx, bus.out_max_idx);
      end
`endif
      @(negedge clk);
      // Clear during a stalled report drops it.
      bus.out_ready = 1'b0;
      for (int i = 0; i < 8; i++) push(16'd20, 16'd0);
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      vectors++;
      if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
         miscompares++;
         $display("FAIL clear_in_report: got in_ready/out_valid=%b required 10", {bus.in_ready, bus.out_valid});
      end
      bus.out_ready = 1'b1;
   endtask

   task automatic test_async_reset();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 8; i++) push(16'd10 + 16'(i), 16'd12);
      vectors++;
      if ({bus.out_valid, bus.out_min, bus.out_max, bus.out_above} !== {1'b1, 16'd10, 16'd17, 4'd5}) begin
         miscompares++;
         $display("FAIL arst_pre_report: got v=%0b min=%0d max=%0d above=%0d required 1/10/17/5",
                  bus.out_valid, bus.out_min, bus.out_max, bus.out_above);
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({bus.out_valid, bus.out_min, bus.out_max, bus.out_above} !== '0) begin
         miscompares++;
         $display("FAIL arst_outputs: got v=%0b min=%0d max=%0d above=%0d required 0/0/0/0",
                  bus.out_valid, bus.out_min, bus.out_max, bus.out_above);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
         miscompares++;
         $display("FAIL arst_release: got in_ready/out_valid=%b required 10", {bus.in_ready, bus.out_valid});
      end
   endtask

   function automatic logic [DW-1:0] b2b_data(int p);
      return DW'((p / 8) * 100 + (((p % 8) * 5) % 8));
   endfunction

   task automatic test_back_to_back();
      int ptr = 0;
      int reports = 0;
      int last_rise = -1;
      logic prev = 1'b0;
      logic acc;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      for (int cyc = 0; cyc < 60 && reports < 3; cyc++) begin
         if (bus.out_valid && !prev) begin
            vectors++;
            if ({bus.out_min, bus.out_max, bus.out_above} !== {16'(reports * 100), 16'(reports * 100 + 7), 4'd4}) begin
               miscompares++;
               $display("FAIL b2b_report%0d: got min=%0d max=%0d above=%0d required %0d/%0d/4",
                        reports, bus.out_min, bus.out_max, bus.out_above, reports * 100, reports * 100 + 7);
            end
`ifdef MINMAX_INDEX_EN
            vectors++;
            if ({bus.out_min_idx, bus.out_max_idx} !== {4'd0, 4'd3}) begin
               miscompares++;
               $display("FAIL b2b_idx%0d: got %0d/%0d required 0/3", reports, bus.out_min_idx, bus.out_max_idx);
            end
`endif
            if (reports > 0) begin
               vectors++;
               if (cyc - last_rise !== 9) begin
                  miscompares++;
                  $display("FAIL b2b_period%0d: got %0d cycles required 9", reports, cyc - last_rise);
               end
            end
            last_rise = cyc;
            reports++;
         end
         prev        = bus.out_valid;
         bus.in_data = b2b_data(ptr);
         bus.thr     = DW'((ptr / 8) * 100 + 3);
         acc         = bus.in_ready;
         @(negedge clk);
         if (acc) ptr++;
      end
      bus.in_valid = 1'b0;
      vectors++;
      if (reports !== 3) begin
         miscompares++;
         $display("FAIL b2b_count: got %0d reports required 3", reports);
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.clear     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.thr       = '0;
      bus.out_ready = 1'b0;
      #12 rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_basic();
      test_backpressure();
      test_all_equal();
      test_clear();
      test_async_reset();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
